interrupt_priority_resolver: RTL and testbench

Clocked interrupt-request front end of the 8259 PIC. It sits directly upstream of the control logic: it captures IR0–IR7 into the IRR (edge or level mode) and applies the OCW1 mask. It resolves fully-nested, rotating priority against the ISR and raises the interrupt request. It also maintains the ISR across the two INTA acknowledge phases and EOI commands, and supplies the highest-priority ID and vector strobe that the control logic consumes.

---
 rtl/pic_pkg.sv | 45 ++++
 rtl/pic_prio_find.sv | 17 +
 rtl/interrupt_priority_resolver.sv | 143 ++++++++++++++
 tb/tb_interrupt_priority_resolver.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259-style interrupt front end.
// prio_find scans a request vector in rotating order starting just above lp.
package pic_pkg;

  localparam int unsigned NUM_IR = 8;
  localparam int unsigned IdW    = 3;

  typedef logic [IdW-1:0] ir_id_t;

  typedef enum logic [0:0] {
    StIdle,
    StAck1
  } ack_state_e;

  typedef enum logic [0:0] {
    EoiNonSpecific = 1'b0,
    EoiSpecific    = 1'b1
  } eoi_cmd_e;

  typedef struct packed {
    logic   found;
    ir_id_t id;
  } prio_res_t;

  function automatic prio_res_t prio_find(input logic [NUM_IR-1:0] vec, input ir_id_t lp);
    prio_res_t res;
    ir_id_t    idx;
    res = '0;
    // Walk from lowest (lp) up to highest (lp+1) so the highest match is kept.
    for (int k = NUM_IR; k >= 1; k--) begin
      idx = lp + ir_id_t'(k);
      if (vec[idx]) begin
        res.found = 1'b1;
        res.id    = idx;
      end
    end
    return res;
  endfunction

  // 0 = highest priority, 7 = lowest.
  function automatic ir_id_t prio_rank(input ir_id_t id, input ir_id_t lp);
    return id - lp - 3'd1;
  endfunction

endpackage

// File: rtl/pic_prio_find.sv
// Combinational rotating priority encoder over an 8-bit request vector.
module pic_prio_find
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] vec_i,
  input  ir_id_t            lp_i,
  output logic              found_o,
  output ir_id_t            id_o
);

  prio_res_t res;

  assign res     = prio_find(vec_i, lp_i);
  assign found_o = res.found;
  assign id_o    = res.id;

endmodule

// File: rtl/interrupt_priority_resolver.sv
// IRR capture, masking, fully-nested rotating priority, ISR maintenance across the
// two INTA phases and EOI commands, with registered request/ID/vector-strobe outputs.
module interrupt_priority_resolver
  import pic_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IR-1:0] ir_in,
  input  logic              ltim,
  input  logic [NUM_IR-1:0] mask,
  input  logic              aeoi,
  input  logic              auto_rotate,
  input  logic              first_ack,
  input  logic              second_ack,
  input  logic              eoi_valid,
  input  logic              eoi_specific,
  input  logic [IdW-1:0]    eoi_id,
  input  logic              eoi_rotate,
  output logic [NUM_IR-1:0] irr,
  output logic [NUM_IR-1:0] isr,
  output logic              int_req,
  output logic [IdW-1:0]    highest_id,
  output logic              vec_flag
);

  logic [NUM_IR-1:0] ir_q, irr_q, irr_d, isr_q, isr_d, cand_vec;
  ack_state_e        state_q, state_d;
  ir_id_t            lp_q, lp_d, grant_q, grant_d, hid_q, hid_d;
  logic              fa_q, fa_qq, sa_q, sa_qq;
  logic              int_req_q, int_req_d, vec_q, vec_d;
  logic              cand_found, isr_found;
  ir_id_t            cand_id, isr_id;
  logic              do_grant, do_vec;

  assign cand_vec = irr_q & ~mask;

  pic_prio_find u_cand_find (
    .vec_i   (cand_vec),
    .lp_i    (lp_q),
    .found_o (cand_found),
    .id_o    (cand_id)
  );

  pic_prio_find u_isr_find (
    .vec_i   (isr_q),
    .lp_i    (lp_q),
    .found_o (isr_found),
    .id_o    (isr_id)
  );

  always_comb begin
    do_grant = (state_q == StIdle) && fa_q && !fa_qq;
    do_vec   = (state_q == StAck1) && sa_q && !sa_qq;

    state_d = state_q;
    if (do_grant) state_d = StAck1;
    if (do_vec)   state_d = StIdle;

    grant_d = grant_q;
    if (do_grant) grant_d = cand_found ? cand_id : 3'd7;

    irr_d = irr_q;
    if (ltim) begin
      irr_d = ir_in;
    end else begin
      for (int i = 0; i < NUM_IR; i++) begin
        // A fresh edge beats the grant-clear of the same bit.
        if (ir_in[i] && !ir_q[i])    irr_d[i] = 1'b1;
        else if (!ir_in[i])          irr_d[i] = 1'b0;
        else if (do_grant && cand_found && cand_id == ir_id_t'(i)) irr_d[i] = 1'b0;
      end
    end

    isr_d = isr_q;
    lp_d  = lp_q;
    if (do_grant && cand_found) isr_d[cand_id] = 1'b1;
    if (do_vec && aeoi) begin
      isr_d[grant_q] = 1'b0;
      if (auto_rotate) lp_d = grant_q;
    end
    if (eoi_valid) begin
      if (eoi_cmd_e'(eoi_specific) == EoiSpecific) begin
        isr_d[eoi_id] = 1'b0;
      end else if (isr_found) begin
        isr_d[isr_id] = 1'b0;
        if (eoi_rotate) lp_d = isr_id;
      end
    end

    int_req_d = (state_d == StIdle) && cand_found &&
                (!isr_found || (prio_rank(cand_id, lp_q) < prio_rank(isr_id, lp_q)));
    vec_d     = do_vec;

    if (eoi_valid && (eoi_cmd_e'(eoi_specific) == EoiNonSpecific) && isr_found) begin
      hid_d = isr_id;
    end else if (do_grant) begin
      hid_d = grant_d;
    end else if (state_q == StAck1) begin
      hid_d = grant_q;
    end else begin
      hid_d = cand_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q      <= '0;
      irr_q     <= '0;
      isr_q     <= '0;
      state_q   <= StIdle;
      lp_q      <= 3'd7;
      grant_q   <= '0;
      hid_q     <= '0;
      fa_q      <= 1'b0;
      fa_qq     <= 1'b0;
      sa_q      <= 1'b0;
      sa_qq     <= 1'b0;
      int_req_q <= 1'b0;
      vec_q     <= 1'b0;
    end else begin
      ir_q      <= ir_in;
      irr_q     <= irr_d;
      isr_q     <= isr_d;
      state_q   <= state_d;
      lp_q      <= lp_d;
      grant_q   <= grant_d;
      hid_q     <= hid_d;
      fa_q      <= first_ack;
      fa_qq     <= fa_q;
      sa_q      <= second_ack;
      sa_qq     <= sa_q;
      int_req_q <= int_req_d;
      vec_q     <= vec_d;
    end
  end

  assign irr        = irr_q;
  assign isr        = isr_q;
  assign int_req    = int_req_q;
  assign highest_id = hid_q;
  assign vec_flag   = vec_q;

endmodule

// File: tb/tb_interrupt_priority_resolver.sv
// Self-checking bench: a table of single-request vectors via a scoreboard queue,
// then hand-written acknowledge, nesting, rotation, spurious and reset sequences.
module tb_interrupt_priority_resolver;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ir_in, mask;
  logic       ltim, aeoi, auto_rotate, first_ack, second_ack;
  logic       eoi_valid, eoi_specific, eoi_rotate;
  logic [2:0] eoi_id;
  logic [7:0] irr, isr;
  logic       int_req, vec_flag;
  logic [2:0] highest_id;

  int total = 0;
  int bad   = 0;

  interrupt_priority_resolver dut (
    .clk          (clk),
    .rst          (rst),
    .ir_in        (ir_in),
    .ltim         (ltim),
    .mask         (mask),
    .aeoi         (aeoi),
    .auto_rotate  (auto_rotate),
    .first_ack    (first_ack),
    .second_ack   (second_ack),
    .eoi_valid    (eoi_valid),
    .eoi_specific (eoi_specific),
    .eoi_id       (eoi_id),
    .eoi_rotate   (eoi_rotate),
    .irr          (irr),
    .isr          (isr),
    .int_req      (int_req),
    .highest_id   (highest_id),
    .vec_flag     (vec_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ltim;
    logic [7:0] mask;
    logic [7:0] ir;
    logic [7:0] irr;
    logic       req;
    logic [2:0] id;
    logic       chk_id;
  } vec_t;

  typedef struct {
    logic [7:0] irr;
    logic       req;
    logic [2:0] id;
    logic       chk_id;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ir_in = '0; mask = '0; ltim = 1'b0; aeoi = 1'b0; auto_rotate = 1'b0;
    first_ack = 1'b0; second_ack = 1'b0;
    eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_id = '0; eoi_rotate = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic ack1();
    first_ack = 1'b1;
    tick();
    tick();
    first_ack = 1'b0;
  endtask

  task automatic ack2();
    second_ack = 1'b1;
    tick();
    tick();
    second_ack = 1'b0;
  endtask

  initial begin
    exp_t e;
    vecs[0] = '{1'b0, 8'h00, 8'h08, 8'h08, 1'b1, 3'd3, 1'b1};
    vecs[1] = '{1'b0, 8'h00, 8'h81, 8'h81, 1'b1, 3'd0, 1'b1};
    vecs[2] = '{1'b0, 8'h01, 8'h81, 8'h81, 1'b1, 3'd7, 1'b1};
    vecs[3] = '{1'b0, 8'hFF, 8'h0F, 8'h0F, 1'b0, 3'd0, 1'b0};
    vecs[4] = '{1'b1, 8'h00, 8'h60, 8'h60, 1'b1, 3'd5, 1'b1};
    vecs[5] = '{1'b1, 8'h20, 8'h60, 8'h60, 1'b1, 3'd6, 1'b1};

    do_reset();
    chk("rst_irr", irr, 8'h00);
    chk("rst_isr", isr, 8'h00);
    chk("rst_req", int_req, 1'b0);
    chk("rst_vec", vec_flag, 1'b0);
    chk("rst_id", highest_id, 3'd0);

    // Table vectors: drive, push expectation, pop two clocks later.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      ltim  = vecs[v].ltim;
      mask  = vecs[v].mask;
      ir_in = vecs[v].ir;
      sb.push_back('{vecs[v].irr, vecs[v].req, vecs[v].id, vecs[v].chk_id});
      tick();
      tick();
      e = sb.pop_front();
      chk($sformatf("vec%0d_irr", v), irr, e.irr);
      chk($sformatf("vec%0d_req", v), int_req, e.req);
      if (e.chk_id) chk($sformatf("vec%0d_id", v), highest_id, e.id);
    end

    // Edge IR3, full acknowledge, non-specific EOI.
    do_reset();
    ir_in = 8'h08;
    tick();
    chk("ir3_irr_1clk", irr, 8'h08);
    chk("ir3_req_1clk", int_req, 1'b0);
    tick();
    chk("ir3_req", int_req, 1'b1);
    chk("ir3_id", highest_id, 3'd3);
    ack1();
    chk("ack1_isr", isr, 8'h08);
    chk("ack1_irr", irr, 8'h00);
    chk("ack1_req_low", int_req, 1'b0);
    ack2();
    chk("ack2_vec", vec_flag, 1'b1);
    chk("ack2_id", highest_id, 3'd3);
    tick();
    chk("ack2_vec_once", vec_flag, 1'b0);
    chk("ack2_isr_kept", isr, 8'h08);
    eoi_valid = 1'b1;
    tick();
    eoi_valid = 1'b0;
    chk("eoi_isr", isr, 8'h00);
    chk("eoi_id", highest_id, 3'd3);

    // Nesting: IR5 in service blocks IR6 but not IR2.
    do_reset();
    ir_in = 8'h20;
    tick();
    tick();
    ack1();
    ack2();
    chk("nest_isr", isr, 8'h20);
    ir_in = 8'h00;
    tick();
    ir_in = 8'h40;
    tick();
    tick();
    chk("nest_ir6_irr", irr, 8'h40);
    chk("nest_ir6_blocked", int_req, 1'b0);
    ir_in = 8'h44;
    tick();
    tick();
    chk("nest_ir2_req", int_req, 1'b1);
    chk("nest_ir2_id", highest_id, 3'd2);

    // Level mode with mask.
    do_reset();
    ltim = 1'b1;
    mask = 8'h04;
    ir_in = 8'h14;
    tick();
    tick();
    chk("lvl_id", highest_id, 3'd4);
    chk("lvl_req", int_req, 1'b1);
    ir_in = 8'h04;
    tick();
    chk("lvl_drop_irr", irr, 8'h04);
    tick();
    chk("lvl_drop_req", int_req, 1'b0);

    // Auto-rotate on AEOI: IR0 served becomes lowest priority.
    do_reset();
    aeoi = 1'b1;
    auto_rotate = 1'b1;
    ir_in = 8'h01;
    tick();
    tick();
    ack1();
    ack2();
    chk("rot_vec", vec_flag, 1'b1);
    chk("rot_aeoi_isr", isr, 8'h00);
    ir_in = 8'h00;
    tick();
    ir_in = 8'h03;
    tick();
    tick();
    chk("rot_next_id", highest_id, 3'd1);
    aeoi = 1'b0;
    ack1();
    chk("rot_grant_isr", isr, 8'h02);
    chk("rot_grant_id", highest_id, 3'd1);

    // Spurious acknowledge, then reset while in ACK1.
    do_reset();
    ack1();
    chk("spur_id", highest_id, 3'd7);
    chk("spur_isr", isr, 8'h00);
    second_ack = 1'b1;
    rst = 1'b1;
    tick();
    chk("midrst_id", highest_id, 3'd0);
    chk("midrst_isr", isr, 8'h00);
    chk("midrst_req", int_req, 1'b0);
    chk("midrst_vec", vec_flag, 1'b0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("midrst_novec%0d", c), vec_flag, 1'b0);
    end
    second_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
